pkt_tx_engine: RTL and testbench

//  Transmit side of the packet buffer. On a start pulse it reads one stored packet
//  (words head_addr..tail_addr) from the pipeline's packet memory and drives it onto
//  the NetFPGA 64-bit data/ctrl/wr/rdy output stream. It sits after the processing

---
 rtl/pkt_tx_engine.sv | 183 ++++++++++++++++++
 tb/tb_pkt_tx_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_engine.sv
// Packet transmit engine: streams one stored packet (head..tail) from packet memory
// onto the 64-bit data/ctrl/wr/rdy output interface through a 2-entry output buffer.
module pkt_tx_engine #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ADDR_WIDTH-1:0]            head_addr,
    input  logic [ADDR_WIDTH-1:0]            tail_addr,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      pkt_sent_cnt,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy
);

    localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   rd_left;
    logic [ADDR_WIDTH-1:0]   wr_left;
    logic [ADDR_WIDTH-1:0]   pkt_len;
    logic [1:0]              occ;
    logic                    pend;
    logic [WORD_W-1:0]       entry0;
    logic [WORD_W-1:0]       entry1;
    logic [2:0]              slots;
    logic                    can_send;
    logic                    last_acc;
    logic                    launch;
    logic                    flush;

    assign pkt_len  = ADDR_WIDTH'(tail_addr - head_addr + 1'b1);
    assign launch   = (state == IDLE) & start & ~abort;
    assign flush    = (state != IDLE) & abort;
    assign can_send = (state == SEND) & (occ != 2'd0) & out_rdy;
    assign last_acc = can_send & (wr_left == ADDR_WIDTH'(1));
    // Occupancy after this cycle's consume plus the word landing from last cycle's read.
    assign slots    = 3'(occ) + 3'(pend) - 3'(can_send);

    assign mem_rd_addr = rd_addr;
    assign out_data    = entry0[DATA_WIDTH-1:0];
    assign out_ctrl    = entry0[WORD_W-1:DATA_WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if ((wr_left == '0) || last_acc) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_wr    = 1'b0;
        mem_rd_en = 1'b0;
        unique case (state)
            SEND: begin
                busy      = 1'b1;
                out_wr    = can_send;
                mem_rd_en = ~abort & (rd_left != '0) & (slots < 3'd2);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Read address and remaining-word counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_left <= '0;
            wr_left <= '0;
        end else if (launch) begin
            rd_addr <= head_addr;
            rd_left <= pkt_len;
            wr_left <= pkt_len;
        end else begin
            if (mem_rd_en) begin
                rd_addr <= ADDR_WIDTH'(rd_addr + 1'b1);
                rd_left <= ADDR_WIDTH'(rd_left - 1'b1);
            end
            if (out_wr) begin
                wr_left <= ADDR_WIDTH'(wr_left - 1'b1);
            end
        end
    end

    // Output buffer: entry0 is always the head; read data lands one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            pend   <= 1'b0;
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            pend <= mem_rd_en;
            unique case ({pend, out_wr})
                2'b10: begin
                    if (occ == 2'd0) begin
                        entry0 <= mem_rd_data;
                    end else begin
                        entry1 <= mem_rd_data;
                    end
                    occ <= 2'(occ + 2'd1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= 2'(occ - 2'd1);
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        entry0 <= mem_rd_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completed-packet counter; an abort during DONE suppresses the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sent_cnt <= '0;
        end else if ((state == DONE) && !abort) begin
            pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_tx_engine.sv
// Directed self-checking bench for pkt_tx_engine with a 1-cycle-latency memory model.
module tb_pkt_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  head_addr;
    logic [7:0]  tail_addr;
    logic        busy;
    logic        done;
    logic [31:0] pkt_sent_cnt;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [71:0] mem_rd_data = '0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [71:0] rx[$];
    int first_wr, last_wr, done_cyc, done_cnt, issued, accepted, e0;

    logic       rd_req = 1'b0;
    logic [7:0] rd_a   = '0;

    pkt_tx_engine #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .head_addr    (head_addr),
        .tail_addr    (tail_addr),
        .busy         (busy),
        .done         (done),
        .pkt_sent_cnt (pkt_sent_cnt),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stored word at address a: ctrl = a^0x5A, data = 0xC0DE0000_000000aa
    function automatic logic [71:0] word_at(input logic [7:0] a);
        return {a ^ 8'h5A, 32'hC0DE_0000, 24'h0, a};
    endfunction

    // Memory: request seen mid-cycle, data presented for exactly the next cycle
    always @(negedge clk) begin
        rd_req = mem_rd_en;
        rd_a   = mem_rd_addr;
    end
    always @(posedge clk) mem_rd_data <= rd_req ? word_at(rd_a) : {9{8'hEE}};

    // Stream monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) issued++;
            if (out_wr) begin
                accepted++;
                rx.push_back({out_ctrl, out_data});
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                check("wr_while_not_rdy", 72'(out_wr & ~out_rdy), 72'd0);
                check("outstanding_gt2", 72'((issued - accepted) > 2), 72'd0);
            end
        end
    end

    task automatic clear_stats();
        rx.delete();
        first_wr = -1;
        last_wr  = -1;
        done_cyc = -1;
        done_cnt = 0;
        issued   = 0;
        accepted = 0;
    endtask

    task automatic start_pkt(input logic [7:0] h, input logic [7:0] t);
        head_addr = h;
        tail_addr = t;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    // mode 0: out_rdy held high; mode 1: out_rdy cycles 1,0,0,1
    task automatic wait_done(input int mode, input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            if (mode == 1) out_rdy = ((k % 4) == 0) || ((k % 4) == 3);
        end
        out_rdy = 1'b1;
        check("done_seen", 72'(done_cnt != 0), 72'd1);
    endtask

    task automatic verify(input logic [7:0] h, input int n);
        @(posedge clk); #1;
        check("done_once", 72'(done_cnt), 72'(1));
        check("word_count", 72'(rx.size()), 72'(n));
        for (int i = 0; i < n; i++) begin
            check("word", (i < rx.size()) ? rx[i] : 72'h0, word_at(8'(h + 8'(i))));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_done", 72'(done), 72'd0);
        check("rst_out_wr", 72'(out_wr), 72'd0);
        check("rst_mem_rd_en", 72'(mem_rd_en), 72'd0);
        check("rst_mem_rd_addr", 72'(mem_rd_addr), 72'd0);
        check("rst_out_data", 72'(out_data), 72'd0);
        check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
        check("rst_cnt", 72'(pkt_sent_cnt), 72'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_rdy   = 1'b1;
        head_addr = '0;
        tail_addr = '0;
        clear_stats();
        #12;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 4-word packet: latency, back-to-back streaming, done timing
        clear_stats();
        start_pkt(8'h10, 8'h13);
        wait_done(0, 50);
        check("first_wr_latency", 72'(first_wr - e0), 72'd2);
        check("back_to_back", 72'(last_wr - first_wr), 72'd3);
        check("done_after_last", 72'(done_cyc - last_wr), 72'd1);
        verify(8'h10, 4);
        check("cnt_pkt1", 72'(pkt_sent_cnt), 72'd1);

        // single word with its stored ctrl
        clear_stats();
        start_pkt(8'h22, 8'h22);
        wait_done(0, 50);
        verify(8'h22, 1);
        check("ctrl_single", 72'((rx.size() > 0) ? rx[0][71:64] : 8'h00), 72'(8'h22 ^ 8'h5A));
        check("cnt_pkt2", 72'(pkt_sent_cnt), 72'd2);

        // address wrap through the top of memory
        clear_stats();
        start_pkt(8'hFE, 8'h01);
        wait_done(0, 50);
        verify(8'hFE, 4);
        check("cnt_pkt3", 72'(pkt_sent_cnt), 72'd3);

        // 8 words under backpressure
        clear_stats();
        start_pkt(8'h30, 8'h37);
        wait_done(1, 200);
        verify(8'h30, 8);
        check("cnt_pkt4", 72'(pkt_sent_cnt), 72'd4);

        // abort after the 3rd word, then a full new packet
        clear_stats();
        start_pkt(8'h40, 8'h47);
        for (int k = 0; k < 50 && accepted < 3; k++) begin
            @(posedge clk); #1;
        end
        out_rdy = 1'b0;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 72'(busy), 72'd0);
        check("abort_rd_en", 72'(mem_rd_en), 72'd0);
        out_rdy = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 72'(done_cnt), 72'd0);
        check("abort_words", 72'(accepted), 72'd3);
        check("abort_cnt", 72'(pkt_sent_cnt), 72'd4);
        clear_stats();
        start_pkt(8'h50, 8'h53);
        wait_done(0, 50);
        verify(8'h50, 4);
        check("cnt_after_abort", 72'(pkt_sent_cnt), 72'd5);

        // asynchronous reset mid-packet
        clear_stats();
        start_pkt(8'h60, 8'h67);
        for (int k = 0; k < 50 && accepted < 2; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // start while busy must be ignored
        clear_stats();
        start_pkt(8'h70, 8'h75);
        head_addr = 8'h00;
        tail_addr = 8'h03;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, 50);
        verify(8'h70, 6);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("ignored_start_cnt", 72'(pkt_sent_cnt), 72'd1);
        check("ignored_start_idle", 72'(busy), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
